// File: rtl/d_mem_axi_bridge.sv
// Bridges the d_cache strobe/ready memory port onto single-beat AXI3 master transactions, one outstanding.
// Optional macro DMEM_BUS_ERR_EN adds a sticky bus-error flag with the first faulting address.
module d_mem_axi_bridge #(
    parameter logic [3:0] AXI_ID  = 4'd1,
    parameter int         A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    input  logic               m_strobe,
    input  logic [3:0]         m_wen,
    input  logic [1:0]         m_size,
    input  logic               m_rw,
    output logic               m_ready,
    output logic [31:0]        m_dout,
    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [3:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [3:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [3:0]         wid,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
`ifdef DMEM_BUS_ERR_EN
    ,
    output logic               bus_err,
    output logic [A_WIDTH-1:0] bus_err_addr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic [3:0]         wen_q, wen_d;
    logic [1:0]         size_q, size_d;
    logic [31:0]        dout_q, dout_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               m_ready_q, m_ready_d;
    logic               aw_hs, w_hs;
    logic               aw_fin, w_fin;

`ifdef DMEM_BUS_ERR_EN
    logic               bus_err_q, bus_err_d;
    logic [A_WIDTH-1:0] bus_err_addr_q, bus_err_addr_d;
    logic               err_seen;
`endif

    // rlast is implied by single-beat reads; responses matter only for the optional error flag.
    logic unused_resp;
    assign unused_resp = ^{rlast, rresp, bresp};

    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wen_d     = wen_q;
        size_d    = size_q;
        dout_d    = dout_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_ready_d = 1'b0;
`ifdef DMEM_BUS_ERR_EN
        bus_err_d      = bus_err_q;
        bus_err_addr_d = bus_err_addr_q;
        err_seen       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (m_strobe) begin
                    addr_d = m_a;
                    din_d  = m_din;
                    wen_d  = m_wen;
                    size_d = m_size;
                    if (!m_rw) begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = S_WR_ADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rready_q && rvalid) begin
                    dout_d    = rdata;
                    rready_d  = 1'b0;
                    m_ready_d = 1'b1;
                    state_d   = S_DONE;
`ifdef DMEM_BUS_ERR_EN
                    err_seen  = rresp[1];
`endif
                end
            end
            S_WR_ADDR: begin
                // AW and W retire independently; either order or the same cycle is fine.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bready_q && bvalid) begin
                    bready_d  = 1'b0;
                    m_ready_d = 1'b1;
                    state_d   = S_DONE;
`ifdef DMEM_BUS_ERR_EN
                    err_seen  = bresp[1];
`endif
                end
            end
            S_DONE: begin
                // The request still on m_strobe is the one just retired, so it is not re-issued.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DMEM_BUS_ERR_EN
        if (err_seen && !bus_err_q) begin
            bus_err_d      = 1'b1;
            bus_err_addr_d = addr_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            din_q     <= '0;
            wen_q     <= '0;
            size_q    <= '0;
            dout_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            m_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wen_q     <= wen_d;
            size_q    <= size_d;
            dout_q    <= dout_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            m_ready_q <= m_ready_d;
        end
    end

`ifdef DMEM_BUS_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
        end else begin
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
        end
    end

    assign bus_err      = bus_err_q;
    assign bus_err_addr = bus_err_addr_q;
`endif

    assign m_ready = m_ready_q;
    assign m_dout  = dout_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awvalid = awvalid_q;

    assign wid     = AXI_ID;
    assign wdata   = din_q;
    assign wstrb   = wen_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_d_mem_axi_bridge.sv
// Directed bench for d_mem_axi_bridge with a small configurable AXI slave; DMEM_BUS_ERR_EN enables error checks.
module tb_d_mem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_a, m_din, m_dout;
    logic        m_strobe, m_rw, m_ready;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;
    logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
`ifdef DMEM_BUS_ERR_EN
    logic        bus_err;
    logic [31:0] bus_err_addr;
`endif

    // Slave configuration
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic        r_suppress = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    int          ar_wait, aw_wait, w_wait;
    int          ar_count, aw_count, w_count;
    logic        aw_got, w_got;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    d_mem_axi_bridge #(.AXI_ID(4'd1), .A_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
        .m_ready(m_ready), .m_dout(m_dout),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DMEM_BUS_ERR_EN
        , .bus_err(bus_err), .bus_err_addr(bus_err_addr)
`endif
    );

    assign arready = arvalid && (ar_wait >= ar_delay);
    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign rlast   = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
            ar_count <= 0; aw_count <= 0; w_count <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            bvalid <= 1'b0; bresp <= 2'b00;
        end else begin
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                ar_count <= ar_count + 1;
                if (!r_suppress) begin
                    rvalid <= 1'b1;
                    rdata  <= rdata_cfg;
                    rresp  <= rresp_cfg;
                end
            end
            if (awvalid && awready) aw_count <= aw_count + 1;
            if (wvalid && wready) w_count <= w_count + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || (awvalid && awready);
                w_got  <= w_got || (wvalid && wready);
            end
        end
    end

    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (m_ready) break;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                         input logic [3:0] wen, input logic [31:0] din);
        m_a = a; m_rw = rw; m_size = sz; m_wen = wen; m_din = din; m_strobe = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, m_ready} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {arvalid, awvalid, wvalid, rready, bready, m_ready});
        else passes++;
        checks++;
        if (m_dout !== 32'h0) $display("FAIL reset_dout: got %h expected 00000000", m_dout);
        else passes++;
`ifdef DMEM_BUS_ERR_EN
        checks++;
        if (bus_err !== 1'b0 || bus_err_addr !== 32'h0)
            $display("FAIL reset_bus_err: got %b/%h expected 0/00000000", bus_err, bus_err_addr);
        else passes++;
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_word;
        int lat;
        rdata_cfg = 32'h1234_5678;
        issue(32'h1FAF_F020, 1'b0, 2'd2, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h1FAF_F020 || arsize !== 3'd2)
            $display("FAIL rd_ar: got v=%b a=%h s=%0d expected v=1 a=1faff020 s=2", arvalid, araddr, arsize);
        else passes++;
        checks++;
        if (arlen !== 4'd0 || arburst !== 2'b01 || arid !== 4'd1)
            $display("FAIL rd_ar_const: got len=%0d burst=%b id=%0d expected 0/01/1", arlen, arburst, arid);
        else passes++;
        wait_ready(lat);
        checks++;
        if (lat + 1 !== 3) $display("FAIL rd_latency: got %0d expected 3", lat + 1);
        else passes++;
        checks++;
        if (m_dout !== 32'h1234_5678) $display("FAIL rd_dout: got %h expected 12345678", m_dout);
        else passes++;
        m_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ready !== 1'b0 || m_dout !== 32'h1234_5678)
            $display("FAIL rd_hold: got rdy=%b dout=%h expected 0/12345678", m_ready, m_dout);
        else passes++;
        checks++;
        if (ar_count !== 1) $display("FAIL rd_ar_count: got %0d expected 1", ar_count);
        else passes++;
    endtask

    task automatic test_write_byte;
        int lat;
        issue(32'h0000_0103, 1'b1, 2'd0, 4'b1000, 32'hAB00_0000);
        @(negedge clk);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h0000_0103 || awsize !== 3'd0)
            $display("FAIL wr_aw: got av=%b wv=%b a=%h s=%0d expected 1/1/00000103/0", awvalid, wvalid, awaddr, awsize);
        else passes++;
        checks++;
        if (wstrb !== 4'b1000 || wlast !== 1'b1 || wdata !== 32'hAB00_0000 || wid !== 4'd1 || awid !== 4'd1)
            $display("FAIL wr_w: got strb=%b last=%b data=%h wid=%0d awid=%0d expected 1000/1/ab000000/1/1",
                     wstrb, wlast, wdata, wid, awid);
        else passes++;
        wait_ready(lat);
        checks++;
        if (lat + 1 !== 3) $display("FAIL wr_latency: got %0d expected 3", lat + 1);
        else passes++;
        checks++;
        if (m_dout !== 32'h1234_5678) $display("FAIL wr_dout_hold: got %h expected 12345678", m_dout);
        else passes++;
        m_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aw_delay;
        int cyc = 0, aw_hi = 0, w_hi = 0, first_b = 0, aw0, w0;
        aw0 = aw_count; w0 = w_count;
        aw_delay = 3;
        issue(32'h0000_0200, 1'b1, 2'd2, 4'hF, 32'h0BAD_F00D);
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (bready && first_b == 0) first_b = cyc;
            if (m_ready) break;
        end
        checks++;
        if (aw_hi !== 4 || w_hi !== 1)
            $display("FAIL awdly_valid_cycles: got aw=%0d w=%0d expected aw=4 w=1", aw_hi, w_hi);
        else passes++;
        checks++;
        if (first_b !== 5) $display("FAIL awdly_bready: got cycle %0d expected 5", first_b);
        else passes++;
        checks++;
        if (cyc !== 6) $display("FAIL awdly_latency: got %0d expected 6", cyc);
        else passes++;
        checks++;
        if (aw_count - aw0 !== 1 || w_count - w0 !== 1)
            $display("FAIL awdly_beats: got aw=%0d w=%0d expected 1/1", aw_count - aw0, w_count - w0);
        else passes++;
        m_strobe = 1'b0;
        aw_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, ar0;
        ar0 = ar_count;
        rdata_cfg = 32'hCAFE_0001;
        issue(32'h0000_0300, 1'b0, 2'd2, 4'h0, 32'h0);
        wait_ready(lat);
        checks++;
        if (lat !== 3 || m_dout !== 32'hCAFE_0001 || arvalid !== 1'b0)
            $display("FAIL b2b_first: got lat=%0d dout=%h arv=%b expected 3/cafe0001/0", lat, m_dout, arvalid);
        else passes++;
        m_a = 32'h0000_0304;
        rdata_cfg = 32'hCAFE_0002;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || ar_count - ar0 !== 1)
            $display("FAIL b2b_idle_gap: got arv=%b ars=%0d expected 0/1", arvalid, ar_count - ar0);
        else passes++;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_0304)
            $display("FAIL b2b_second_ar: got v=%b a=%h expected 1/00000304", arvalid, araddr);
        else passes++;
        wait_ready(lat);
        checks++;
        if (lat !== 2 || m_dout !== 32'hCAFE_0002)
            $display("FAIL b2b_second: got lat=%0d dout=%h expected 2/cafe0002", lat, m_dout);
        else passes++;
        m_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (ar_count - ar0 !== 2 || arvalid !== 1'b0)
            $display("FAIL b2b_ar_count: got %0d arv=%b expected 2/0", ar_count - ar0, arvalid);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int lat, stray = 0;
        r_suppress = 1'b1;
        issue(32'h0000_0400, 1'b0, 2'd2, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rready !== 1'b1) $display("FAIL rstmid_rready_before: got %b expected 1", rready);
        else passes++;
        rst = 1'b1;
        m_strobe = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || m_ready !== 1'b0 || m_dout !== 32'h0)
            $display("FAIL rstmid_drop: got rr=%b arv=%b rdy=%b dout=%h expected 0/0/0/00000000",
                     rready, arvalid, m_ready, m_dout);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        r_suppress = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (arvalid || rready || m_ready) stray++;
        end
        checks++;
        if (stray !== 0) $display("FAIL rstmid_idle: got %0d active cycles expected 0", stray);
        else passes++;
        rdata_cfg = 32'h55AA_00FF;
        issue(32'h0000_0500, 1'b0, 2'd2, 4'h0, 32'h0);
        wait_ready(lat);
        checks++;
        if (lat !== 3 || m_dout !== 32'h55AA_00FF)
            $display("FAIL rstmid_recover: got lat=%0d dout=%h expected 3/55aa00ff", lat, m_dout);
        else passes++;
        m_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bus_err;
        int lat;
        bresp_cfg = 2'b10;
        issue(32'h1FAF_0000, 1'b1, 2'd2, 4'hF, 32'h1111_2222);
        wait_ready(lat);
        checks++;
        if (lat !== 3) $display("FAIL err_wr_completes: got lat=%0d expected 3", lat);
        else passes++;
        m_strobe = 1'b0;
        bresp_cfg = 2'b00;
        @(negedge clk);
`ifdef DMEM_BUS_ERR_EN
        checks++;
        if (bus_err !== 1'b1 || bus_err_addr !== 32'h1FAF_0000)
            $display("FAIL err_first: got %b/%h expected 1/1faf0000", bus_err, bus_err_addr);
        else passes++;
`endif
        rresp_cfg = 2'b11;
        rdata_cfg = 32'hDEAD_BEEF;
        issue(32'h0000_4000, 1'b0, 2'd2, 4'h0, 32'h0);
        wait_ready(lat);
        checks++;
        if (lat !== 3 || m_dout !== 32'hDEAD_BEEF)
            $display("FAIL err_rd_completes: got lat=%0d dout=%h expected 3/deadbeef", lat, m_dout);
        else passes++;
        m_strobe = 1'b0;
        rresp_cfg = 2'b00;
        @(negedge clk);
`ifdef DMEM_BUS_ERR_EN
        checks++;
        if (bus_err !== 1'b1 || bus_err_addr !== 32'h1FAF_0000)
            $display("FAIL err_sticky: got %b/%h expected 1/1faf0000", bus_err, bus_err_addr);
        else passes++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        m_a = 32'h0; m_din = 32'h0; m_strobe = 1'b0; m_wen = 4'h0; m_size = 2'd0; m_rw = 1'b0;
        test_reset();
        test_read_word();
        test_write_byte();
        test_aw_delay();
        test_back_to_back();
        test_reset_mid();
        test_bus_err();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
